// File: rtl/energy_best_tracker.sv
// energy_best_tracker
//
// Tracks the minimum signed Ising energy seen on the energy stream and the spin
// vector that produced it. It counts consecutive non-improving samples. When
// that count reaches patience_i, it declares convergence and holds the best
// result on a valid/ready handshake.
//
// Optional feature macro: ENERGY_BEST_TRACKER_TIE_UPDATE_EN
//   defined   - a sample equal to the current best counts as an improvement, and
//               the newest spin vector replaces the stored one
//   undefined - equality is non-improving, and the oldest best spin is kept
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   en_i              enable; low freezes all state and blocks both handshakes
//   clear_i           synchronous return to IDLE; a simultaneous sample is dropped
//   patience_i        non-improving samples before convergence, 0 = never
//   energy_valid_i    sample valid
//   energy_ready_o    sample accepted when high together with valid
//   energy_i, spin_i  energy sample and its spin vector
//   best_valid_o      at least one sample held since the last clear
//   best_energy_o     minimum energy so far
//   best_spin_o       spin vector belonging to best_energy_o
//   improved_o        one-cycle pulse after a handshake that updated the best
//   sample_cnt_o      accepted samples since the last clear, saturating
//   result_valid_o    converged result available
//   result_ready_i    converged result consumed
module energy_best_tracker #(
  parameter int unsigned DATASPIN         = 256,
  parameter int unsigned ENERGY_TOTAL_BIT = 32,
  parameter int unsigned PATIENCE_BIT     = 8,
  parameter int unsigned SAMPLE_CNT_BIT   = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic                               clear_i,
  input  logic        [PATIENCE_BIT-1:0]     patience_i,
  input  logic                               energy_valid_i,
  output logic                               energy_ready_o,
  input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
  input  logic        [DATASPIN-1:0]         spin_i,
  output logic                               best_valid_o,
  output logic signed [ENERGY_TOTAL_BIT-1:0] best_energy_o,
  output logic        [DATASPIN-1:0]         best_spin_o,
  output logic                               improved_o,
  output logic        [SAMPLE_CNT_BIT-1:0]   sample_cnt_o,
  output logic                               result_valid_o,
  input  logic                               result_ready_i
);

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StDone
  } state_e;

  state_e                              state_q;
  logic                                accept_q;
  logic                                best_valid_q;
  logic signed [ENERGY_TOTAL_BIT-1:0]  best_energy_q;
  logic        [DATASPIN-1:0]          best_spin_q;
  logic                                improved_q;
  logic        [PATIENCE_BIT-1:0]      stall_q;
  logic        [SAMPLE_CNT_BIT-1:0]    sample_cnt_q;

  logic                                sample_hs;
  logic                                result_hs;
  logic                                better;
  logic                                stall_hit;
  logic        [PATIENCE_BIT-1:0]      stall_inc;
  logic        [SAMPLE_CNT_BIT-1:0]    sample_cnt_inc;

  // accept_q is a registered "not DONE" flag. It is cleared by reset, so
  // energy_ready_o reads 0 during reset even with en_i high. It is updated to
  // the next-state value, so it follows the FSM without a cycle of lag.
  assign energy_ready_o = en_i && accept_q;
  assign sample_hs      = energy_valid_i && energy_ready_o;
  assign result_hs      = en_i && result_valid_o && result_ready_i;

`ifdef ENERGY_BEST_TRACKER_TIE_UPDATE_EN
  assign better = (energy_i <= best_energy_q);
`else
  assign better = (energy_i < best_energy_q);
`endif

  // Both counters saturate at all-ones.
  assign stall_inc      = (&stall_q) ? stall_q : stall_q + PATIENCE_BIT'(1);
  assign sample_cnt_inc = (&sample_cnt_q) ? sample_cnt_q : sample_cnt_q + SAMPLE_CNT_BIT'(1);

  // Equality against the live patience value. Lowering patience below a
  // saturated stall count therefore never converges.
  assign stall_hit = (patience_i != '0) && (stall_inc == patience_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      accept_q      <= 1'b0;
      best_valid_q  <= 1'b0;
      best_energy_q <= '0;
      best_spin_q   <= '0;
      improved_q    <= 1'b0;
      stall_q       <= '0;
      sample_cnt_q  <= '0;
    end else if (en_i) begin
      improved_q <= 1'b0;
      accept_q   <= (state_q != StDone);
      if (clear_i) begin
        // Best energy/spin are kept; only the "held" flag and counters go.
        state_q      <= StIdle;
        accept_q     <= 1'b1;
        best_valid_q <= 1'b0;
        stall_q      <= '0;
        sample_cnt_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (sample_hs) begin
              state_q       <= StTrack;
              best_valid_q  <= 1'b1;
              best_energy_q <= energy_i;
              best_spin_q   <= spin_i;
              improved_q    <= 1'b1;
              stall_q       <= '0;
              sample_cnt_q  <= sample_cnt_inc;
            end
          end
          StTrack: begin
            if (sample_hs) begin
              sample_cnt_q <= sample_cnt_inc;
              if (better) begin
                best_energy_q <= energy_i;
                best_spin_q   <= spin_i;
                improved_q    <= 1'b1;
                stall_q       <= '0;
              end else begin
                stall_q <= stall_inc;
                if (stall_hit) begin
                  state_q  <= StDone;
                  accept_q <= 1'b0;
                end
              end
            end
          end
          StDone: begin
            if (result_hs) begin
              state_q      <= StIdle;
              accept_q     <= 1'b1;
              best_valid_q <= 1'b0;
              stall_q      <= '0;
              sample_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= StIdle;
            accept_q <= 1'b1;
          end
        endcase
      end
    end else begin
      // While disabled, the update pulse is not repeated.
      improved_q <= 1'b0;
    end
  end

  assign best_valid_o   = best_valid_q;
  assign best_energy_o  = best_energy_q;
  assign best_spin_o    = best_spin_q;
  assign improved_o     = improved_q;
  assign sample_cnt_o   = sample_cnt_q;
  assign result_valid_o = (state_q == StDone);

endmodule
